mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Sequences the single-ported unified RAM between the instruction-fetch requester and the data (load/store) requester of the pipelined datapath.
- Sits between the fetch and memory stages and the RAM.
- Registers each grant and holds RAM address, store data and strobes stable until the RAM reports completion.
- Data requests have priority, with a bounded-starvation guarantee for instruction fetch.

Parameters:
ADDR_W  32  width of word addresses
DATA_W  32  width of load/store data
MAX_DSTREAK  4  max consecutive data grants while a fetch waits (range 1..15)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction fetch request
iaddr  in  ADDR_W  fetch address
iwait  out  1  0 for exactly the completion cycle of a fetch, else 1
iload  out  DATA_W  fetched word, valid when iwait=0
dREN  in  1  data read request
dWEN  in  1  data write request (dREN&dWEN is illegal; write wins)
daddr  in  ADDR_W  data address
dstore  in  DATA_W  store data
dwait  out  1  0 for exactly the completion cycle of a data access, else 1
dload  out  DATA_W  loaded word, valid when dwait=0
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (done this cycle), 3 ERROR
streak  out  4  current consecutive-data-grant count (debug)

Behaviour:
- Reset (async): state=IDLE. ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0, streak=0, latched op/addr/data=0. Reset during an access abandons it; no completion is reported.
- States: IDLE, IFETCH, DACCESS.
- IDLE, in priority order at the clock edge:
  - If (dREN|dWEN) and !(iREN && streak==MAX_DSTREAK): latch daddr, dstore and op (write if dWEN), go to DACCESS.
  - Else if iREN: latch iaddr, go to IFETCH.
  - Else stay in IDLE.
  - All RAM strobes are 0 in IDLE.
- Grant latency: a request seen in IDLE at edge N drives the RAM strobes from cycle N+1.
- IFETCH: ramREN=1, ramaddr=latched addr.
- DACCESS: ramREN=!op and ramWEN=op; ramaddr and ramstore come from the latches.
- RAM signals come only from latches, so requester input changes after the grant do not reach the RAM.
- Completion:
  - Occurs in the cycle ramstate==ACCESS while in IFETCH or DACCESS.
  - In that cycle the matching wait output goes 0 (combinational) and iload/dload=ramload (reads).
  - Next state is IDLE. Minimum spacing between two accesses is therefore one idle cycle.
- ramstate BUSY, FREE or ERROR: hold the state and strobes. ERROR is treated as not done; the RAM retries.
- Withdrawn request (requester drops REN/WEN while granted): the access still runs to completion, the wait pulse is still produced, and the requester ignores it.
- Streak counter, saturating at MAX_DSTREAK:
  - Data completion with iREN=1: streak+1.
  - Data completion with iREN=0: streak=0.
  - Instruction completion: streak=0.
- Simultaneous fetch and data request in IDLE: data wins unless streak==MAX_DSTREAK, in which case the fetch wins.
- iwait and dwait are never both 0 in the same cycle.
- Illegal dREN&dWEN: performed as a write.

Test Plan:
- Reset: nRST low mid-DACCESS write with ramstate=BUSY → ramWEN=0 immediately, state IDLE, dwait=1, no completion pulse after release.
- Single fetch: iREN=1, iaddr=0x40, RAM returns ACCESS on the 3rd strobe cycle with ramload=0x3C08_0004 → ramREN high from cycle 1, iwait=0 for one cycle with iload=0x3C08_0004, then IDLE.
- Priority: iREN and dREN asserted together at 0x40/0x100 → DACCESS first (ramaddr=0x100), fetch granted after data completion plus one idle cycle.
- Starvation bound: iREN held, dWEN held continuously, MAX_DSTREAK=4 → exactly 4 data completions, then a fetch completes and streak returns to 0.
- Latch stability: change daddr from 0x200 to 0x204 and dstore after the grant, with 5 BUSY cycles before ACCESS → ramaddr stays 0x200 and ramstore keeps its original value.
- ERROR handling: ramstate ERROR for 2 cycles then ACCESS → strobes held throughout, single dwait=0 pulse, dload=ramload.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
// Shares one single-ported unified RAM between the instruction-fetch and the
// data (load/store) requesters. Data wins by default; a fetch that has been
// waiting through MAX_DSTREAK back-to-back data grants is served next.
// Every grant is registered. While an access is outstanding, the RAM address,
// store data and strobes come only from the latched copy, so they stay stable.
//
// Ports
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN, iaddr            fetch request / address
//   iwait, iload           fetch completion (low for one cycle) / fetched word
//   dREN, dWEN             data read / write request (write wins if both set)
//   daddr, dstore          data address / store data
//   dwait, dload           data completion (low for one cycle) / loaded word
//   ramREN, ramWEN         RAM read / write strobes
//   ramaddr, ramstore      RAM address / write data
//   ramload, ramstate      RAM read data / status (0 FREE,1 BUSY,2 ACCESS,3 ERROR)
//   streak                 consecutive data grants while a fetch waits (debug)
//
// state   | meaning
// IDLE    | no access outstanding, arbitrating
// IFETCH  | fetch read running on the RAM
// DACCESS | data read or write running on the RAM
module mem_request_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [3:0]        streak
);

  typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  state_t            r_state;
  state_t            w_next;
  logic              r_op;      // 1 = write
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_streak;

  logic w_done;
  logic w_dreq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_i_done;
  logic w_d_done;

  assign w_done   = (ramstate == RAM_ACCESS);
  assign w_dreq   = dREN | dWEN;
  assign w_i_done = (r_state == IFETCH)  && w_done;
  assign w_d_done = (r_state == DACCESS) && w_done;

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    case (r_state)
      IDLE: begin
        // A saturated streak hands the next slot to a waiting fetch.
        if (w_dreq && !(iREN && (r_streak == STREAK_MAX))) begin
          w_next    = DACCESS;
          w_grant_d = 1'b1;
        end else if (iREN) begin
          w_next    = IFETCH;
          w_grant_i = 1'b1;
        end
      end
      IFETCH:  if (w_done) w_next = IDLE;
      DACCESS: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_op     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_streak <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_d) begin
        r_op   <= dWEN;
        r_addr <= daddr;
        r_data <= dstore;
      end else if (w_grant_i) begin
        r_op   <= 1'b0;
        r_addr <= iaddr;
      end
      if (w_i_done) begin
        r_streak <= '0;
      end else if (w_d_done) begin
        // Only counts while a fetch is actually waiting; saturates at the bound.
        if (!iREN)
          r_streak <= '0;
        else if (r_streak != STREAK_MAX)
          r_streak <= r_streak + 4'd1;
      end
    end
  end

  always_comb begin
    ramREN   = (r_state == IFETCH) || ((r_state == DACCESS) && !r_op);
    ramWEN   = (r_state == DACCESS) && r_op;
    ramaddr  = r_addr;
    ramstore = r_data;
    iwait    = !w_i_done;
    dwait    = !w_d_done;
    iload    = w_i_done ? ramload : '0;
    dload    = (w_d_done && !r_op) ? ramload : '0;
    streak   = r_streak;
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic [1:0]    ramstate = 2'd0;
  logic [3:0]    streak;

  mem_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .streak(streak)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ipulse = 0;
  int n_dpulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, described by who owns the
  // RAM and what it was asked to do.
  typedef struct {
    bit          is_i;
    bit          has_data;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  bit          m_busy;
  bit          m_is_i;
  bit          m_write;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int          m_streak;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy   <= 0;
      m_is_i   <= 0;
      m_write  <= 0;
      m_addr   <= '0;
      m_data   <= '0;
      m_streak <= 0;
    end else if (m_busy) begin
      if (ramstate == 2'd2) begin
        m_busy <= 0;
        if (m_is_i)    m_streak <= 0;
        else if (iREN) m_streak <= (m_streak + 1 > MAX) ? MAX : m_streak + 1;
        else           m_streak <= 0;
      end
    end else begin
      if ((dREN || dWEN) && !(iREN && m_streak == MAX)) begin
        m_busy  <= 1;
        m_is_i  <= 0;
        m_write <= dWEN;
        m_addr  <= daddr;
        m_data  <= dstore;
      end else if (iREN) begin
        m_busy  <= 1;
        m_is_i  <= 1;
        m_write <= 0;
        m_addr  <= iaddr;
      end
    end
  end

  // Predictor: the RAM says done this cycle -> one completion is owed.
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (nRST && m_busy && ramstate == 2'd2) begin
      e.is_i     = m_is_i;
      e.has_data = m_is_i || !m_write;
      e.data     = ramload;
      q.push_back(e);
    end
  end

  // Monitor: compares RAM-side view every cycle and pops on each wait pulse.
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (nRST) begin
      chk("ramREN", 32'(ramREN), 32'(m_busy && (m_is_i || !m_write)));
      chk("ramWEN", 32'(ramWEN), 32'(m_busy && !m_is_i && m_write));
      chk("streak", 32'(streak), 32'(m_streak));
      if (m_busy) chk("ramaddr", ramaddr, m_addr);
      if (m_busy && !m_is_i && m_write) chk("ramstore", ramstore, m_data);
      if (!iwait && !dwait) chk("both_waits_low", 32'(iwait | dwait), 32'd1);
      if (!iwait || !dwait) begin
        if (!iwait) n_ipulse++; else n_dpulse++;
        if (q.size() == 0) begin
          chk("unexpected_pulse_queue", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("pulse_kind_is_fetch", 32'(!iwait), 32'(e.is_i));
          if (e.has_data) begin
            if (e.is_i) chk("iload", iload, e.data);
            else        chk("dload", dload, e.data);
          end
        end
      end else if (q.size() != 0) begin
        chk("missing_pulse_queue", 32'(q.size()), 32'd0);
        q.delete();
      end
    end
  end

  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] ds,
                     input logic [1:0] rs, input logic [31:0] rl);
    @(negedge CLK);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  task automatic idle_in(input logic [1:0] rs);
    cyc(0, 0, 0, 0, 0, 0, rs, 32'hDEAD_BEEF);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
    #1;
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_waits", 32'({iwait, dwait}), 32'd3);
    chk("rst_loads", iload | dload, 0);
    chk("rst_streak", 32'(streak), 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
  endtask

  int pi, pd;
  logic [31:0] a_store;
  int r;

  initial begin
    do_reset();

    // Single fetch, RAM completes on the third strobe cycle.
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
    #3 chk("fetch_strobe_c1", 32'({ramREN, iwait}), 32'd3);
    chk("fetch_addr", ramaddr, 32'h40);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'h3C08_0004);
    #3 chk("fetch_iwait", 32'(iwait), 0);
    chk("fetch_iload", iload, 32'h3C08_0004);
    idle_in(2'd0);
    #3 chk("fetch_back_idle", 32'({ramREN, iwait}), 32'd1);

    // Priority: data first, fetch after completion plus one idle cycle.
    do_reset();
    cyc(1, 32'h40, 1, 0, 32'h100, 0, 2'd0, 0);
    cyc(1, 32'h40, 1, 0, 32'h100, 0, 2'd2, 32'h1111);
    #3 chk("prio_data_addr", ramaddr, 32'h100);
    chk("prio_dwait", 32'(dwait), 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    #3 chk("prio_gap_idle", 32'(ramREN), 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'h2222);
    #3 chk("prio_fetch_addr", ramaddr, 32'h40);
    chk("prio_iwait", 32'(iwait), 0);
    idle_in(2'd0);

    // Starvation bound: 4 data completions, then the fetch.
    do_reset();
    pi = n_ipulse; pd = n_dpulse;
    for (int k = 0; k < 10; k++)
      cyc(1, 32'h40, 0, 1, 32'h500 + 32'(k), 32'(k), 2'd2, 32'h7777);
    idle_in(2'd0);
    #3 chk("starve_dcount", 32'(n_dpulse - pd), 32'd4);
    chk("starve_icount", 32'(n_ipulse - pi), 32'd1);
    chk("starve_streak_cleared", 32'(streak), 0);

    // Latch stability across five BUSY cycles.
    a_store = 32'hA5A5_0001;
    cyc(0, 0, 0, 1, 32'h200, a_store, 2'd0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 32'h204, 32'h5A5A_FFFF, 2'd1, 0);
      #3 chk("latch_addr", ramaddr, 32'h200);
      chk("latch_store", ramstore, a_store);
    end
    cyc(0, 0, 0, 0, 32'h204, 32'h5A5A_FFFF, 2'd2, 0);
    #3 chk("latch_dwait", 32'(dwait), 0);
    idle_in(2'd0);

    // ERROR twice then ACCESS on a read.
    cyc(0, 0, 1, 0, 32'h300, 0, 2'd0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 2'd3, 32'h9999);
      #3 chk("err_hold", 32'({ramREN, dwait}), 32'd3);
    end
    pd = n_dpulse;
    cyc(0, 0, 0, 0, 0, 0, 2'd2, 32'hCAFE_F00D);
    #3 chk("err_dload", dload, 32'hCAFE_F00D);
    idle_in(2'd0);
    #3 chk("err_single_pulse", 32'(n_dpulse - pd), 32'd1);

    // Reset in the middle of a BUSY write: no completion afterwards.
    cyc(0, 0, 0, 1, 32'h80, 32'h1234, 2'd0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'd1, 0);
    #3 chk("rst_mid_wen_before", 32'(ramWEN), 1);
    #1 nRST = 0;
    #1 chk("rst_mid_wen", 32'(ramWEN), 0);
    chk("rst_mid_dwait", 32'(dwait), 1);
    pd = n_dpulse;
    @(negedge CLK);
    nRST = 1;
    idle_in(2'd2);
    idle_in(2'd2);
    #3 chk("rst_mid_no_pulse", 32'(n_dpulse - pd), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      cyc(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 5),
          ($urandom_range(0, 9) < 4), $urandom, $urandom,
          (r < 2) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3, $urandom);
    end
    for (int k = 0; k < 4; k++) idle_in(2'd2);
    idle_in(2'd0);
    #3 chk("final_queue_empty", 32'(q.size()), 0);
    chk("final_idle_strobes", 32'({ramREN, ramWEN}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
